vector_lane_alu: RTL and testbench
==================================

VECTOR_LANE_ALU -- requirements
Module: vector_lane_alu

Interface
REQ-001 The block SHALL have the port `clock`, input, width 1: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, width 1: reset, synchronous and active-low.
REQ-003 The block SHALL have the port `start`, input, width 1: request to begin one vector operation, sampled only in IDLE.
REQ-004 The block SHALL have the port `op`, input, width 2: operation select, 00 VADD, 01 VSUB, 10 VAND, 11 VMAX (unsigned).
REQ-005 The block SHALL have the port `vdst`, input, width 2: destination vector register index.
REQ-006 The block SHALL have the port `vdata1`, input, width 32: operand A, the vector register file read port 1.
REQ-007 The block SHALL have the port `vdata2`, input, width 32: operand B, the vector register file read port 2.
REQ-008 The block SHALL have the port `busy`, output, width 1: high whenever the state is not IDLE.
REQ-009 The block SHALL have the port `vdataw`, output, width 32: result vector, driven to the vector register file write data.
REQ-010 The block SHALL have the port `vregw`, output, width 2: destination index, driven to the vector register file write select.
REQ-011 The block SHALL have the port `VRFWrite`, output, width 1: one-cycle write-enable pulse to the vector register file.

Function
REQ-012 The vector SHALL be treated as four 8-bit unsigned lanes; lane i is bits [8i+7:8i], i = 0..3.
REQ-013 The FSM SHALL have exactly three states: IDLE, EXEC, WRITE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL latch vdata1, vdata2, op and vdst, clear the lane counter to 0, and go to EXEC.
REQ-015 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-016 In EXEC, each rising edge SHALL compute lane[counter] from the latched operands, store it into the result register at that lane, and increment the 2-bit counter.
REQ-017 On the edge that computes lane 3, the block SHALL go to WRITE; EXEC therefore lasts exactly 4 cycles.
REQ-018 In WRITE, VRFWrite SHALL be 1, vdataw SHALL hold the full result, and vregw SHALL hold the latched vdst, for exactly one cycle; the next edge SHALL return to IDLE.
REQ-019 Latency SHALL be fixed: if start is accepted on edge E0, VRFWrite is high between edges E4 and E5.
REQ-020 The earliest next acceptance SHALL be E5 + 1 edge, i.e. start sampled in IDLE after E5.
REQ-021 start asserted while busy=1, including the WRITE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-022 Changes on vdata1, vdata2, op or vdst after acceptance SHALL NOT affect the result; a register-file write to a source register mid-operation is therefore harmless.
REQ-023 VADD SHALL compute (A+B) mod 256 per lane.
REQ-024 VSUB SHALL compute (A-B) mod 256 per lane.
REQ-025 VAND SHALL compute bitwise A&B per lane.
REQ-026 VMAX SHALL compute the unsigned maximum of A and B per lane.
REQ-027 Lanes SHALL be independent; no carry or borrow SHALL cross lane boundaries.
REQ-028 Outside WRITE, VRFWrite SHALL be 0; vdataw and vregw SHALL hold their last values, are don't-care to consumers, and SHALL NOT toggle in IDLE.

Reset
REQ-029 reset=0 at a rising edge SHALL force IDLE, counter=0, result register=0 and latched vdst=0, regardless of state and of start.
REQ-030 After reset, outputs SHALL be busy=0, VRFWrite=0, vdataw=32'h0, vregw=2'b00.
REQ-031 A reset asserted during EXEC or WRITE SHALL abort the operation, and no VRFWrite pulse SHALL occur for it.
REQ-032 While reset=0, start SHALL be ignored; the first acceptance SHALL be possible on the first edge with reset=1.

Configuration
REQ-033 The macro VLANE_SAT_EN SHALL select saturating arithmetic.
REQ-034 When VLANE_SAT_EN is defined, VADD SHALL clamp each lane to 8'hFF on overflow and VSUB SHALL clamp each lane to 8'h00 on underflow.
REQ-035 When VLANE_SAT_EN is undefined, VADD and VSUB SHALL wrap modulo 256 as in REQ-023 and REQ-024.
REQ-036 VAND, VMAX, timing and the interface SHALL be identical in both configurations.

Verification
REQ-037 The bench SHALL drive VADD with A=32'h01FF7F10, B=32'h0101_8110 and vdst=2 and SHALL require VRFWrite high exactly 5 cycles after acceptance, vregw=2, and vdataw=32'h0200_0020 (wrap) or 32'h02FF_FF20 (VLANE_SAT_EN).
REQ-038 The bench SHALL drive VSUB with A=32'h0010_0580, B=32'h0120_0380 and SHALL require vdataw=32'hFFF0_0200 (wrap) or 32'h0000_0200 (VLANE_SAT_EN).
REQ-039 The bench SHALL drive VMAX with A=32'h80_01_FF_00 and B=32'h7F_02_FE_01 and SHALL require vdataw=32'h80_02_FF_01; it SHALL also drive VAND with the same operands and require vdataw=32'h00_00_FE_00.
REQ-040 The bench SHALL change vdata1, vdata2 and vdst every cycle after acceptance and SHALL require the result and vregw to reflect only the values latched at acceptance.
REQ-041 The bench SHALL hold start=1 continuously and SHALL require an acceptance every 6 cycles, exactly one VRFWrite pulse per operation, and busy=0 for one cycle between operations.
REQ-042 The bench SHALL assert reset=0 for one edge during the third EXEC cycle and SHALL require that no VRFWrite occurs, that busy=0 and vdataw=0 on the next cycle, and that a new start is then accepted normally.

Source files
------------

// File: rtl/vector_lane_alu.sv
// vector_lane_alu: four-lane (NUM_LANES x VEC_W) vector ALU that runs one
// lane per cycle and writes the whole result back in a single pulse.
//
// Ports:
//   clock     - single clock, rising edge
//   reset     - synchronous, active low
//   start     - begin one operation (sampled only in IDLE)
//   op        - 00 VADD, 01 VSUB, 10 VAND, 11 VMAX (unsigned)
//   vdst      - destination register index
//   vdata1/2  - operands A/B (register file read ports)
//   busy      - high whenever the FSM is not IDLE
//   vdataw    - result vector (register file write data)
//   vregw     - destination index (register file write select)
//   VRFWrite  - one-cycle write enable
//
// Config macro: VLANE_SAT_EN -- saturating VADD/VSUB when defined,
// modulo-2^VEC_W wrap otherwise.
//
// Timing: start accepted on edge E0, lanes 0..3 computed on E1..E4,
// VRFWrite high between E4 and E5, back in IDLE after E5.

module vector_lane_alu_lane #(
  parameter int VEC_W = 8
) (
  input  logic [1:0]       op,
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  output logic [VEC_W-1:0] y
);
  logic [VEC_W-1:0] add_y, sub_y;

`ifdef VLANE_SAT_EN
  logic [VEC_W:0] sum, dif;
  assign sum   = {1'b0, a} + {1'b0, b};
  assign dif   = {1'b0, a} - {1'b0, b};
  // carry out -> overflow, borrow out -> underflow
  assign add_y = sum[VEC_W] ? '1 : sum[VEC_W-1:0];
  assign sub_y = dif[VEC_W] ? '0 : dif[VEC_W-1:0];
`else
  assign add_y = a + b;
  assign sub_y = a - b;
`endif

  always_comb begin
    y = '0;
    case (op)
      2'b00: y = add_y;
      2'b01: y = sub_y;
      2'b10: y = a & b;
      2'b11: y = (a > b) ? a : b;
      default: y = '0;
    endcase
  end
endmodule

module vector_lane_alu #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [1:0]                 vdst,
  input  logic [NUM_LANES*VEC_W-1:0] vdata1,
  input  logic [NUM_LANES*VEC_W-1:0] vdata2,
  output logic                       busy,
  output logic [NUM_LANES*VEC_W-1:0] vdataw,
  output logic [1:0]                 vregw,
  output logic                       VRFWrite
);
  localparam int CNT_W = $clog2(NUM_LANES);

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

  state_t                              state;
  logic [CNT_W-1:0]                    cnt;
  logic [NUM_LANES-1:0][VEC_W-1:0]     a_q, b_q, res_q, lane_res;
  logic [1:0]                          op_q, vdst_q;

  // Every lane has its own ALU; the counter picks which one is committed.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    vector_lane_alu_lane #(.VEC_W(VEC_W)) u_lane (
      .op (op_q),
      .a  (a_q[i]),
      .b  (b_q[i]),
      .y  (lane_res[i])
    );
  end

  // Outputs come straight from the result and destination registers, so
  // they only move on acceptance/EXEC and stay frozen in IDLE.
  assign vdataw = res_q;
  assign vregw  = vdst_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      vdst_q   <= '0;
      res_q    <= '0;
      busy     <= 1'b0;
      VRFWrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= vdata1;
            b_q    <= vdata2;
            op_q   <= op;
            vdst_q <= vdst;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_q[cnt] <= lane_res[cnt];
          cnt        <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NUM_LANES - 1)) begin
            VRFWrite <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          VRFWrite <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          VRFWrite <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vector_lane_alu.sv
// Self-checking bench for vector_lane_alu: a lane-arithmetic reference and
// an acceptance/latency model compared against the DUT every cycle, plus
// directed literal vectors, back-to-back start, and reset-abort scenarios.

module tb_vector_lane_alu;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op, vdst;
  logic [31:0] vdata1, vdata2;
  logic        busy, VRFWrite;
  logic [31:0] vdataw;
  logic [1:0]  vregw;

  int checks = 0;
  int fails  = 0;

  vector_lane_alu dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .vdst     (vdst),
    .vdata1   (vdata1),
    .vdata2   (vdata2),
    .busy     (busy),
    .vdataw   (vdataw),
    .vregw    (vregw),
    .VRFWrite (VRFWrite)
  );

  always #5 clock = ~clock;

  // Reference: per-lane integer arithmetic straight from the op definitions.
  function automatic logic [31:0] ref_alu(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int x, y, z;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = int'(a[8*i +: 8]);
      y = int'(b[8*i +: 8]);
      case (o)
`ifdef VLANE_SAT_EN
        2'd0: z = (x + y > 255) ? 255 : x + y;
        2'd1: z = (x - y < 0) ? 0 : x - y;
`else
        2'd0: z = (x + y) % 256;
        2'd1: z = (x - y + 256) % 256;
`endif
        2'd2: z = x & y;
        default: z = (x > y) ? x : y;
      endcase
      r[8*i +: 8] = z[7:0];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Timing model: ph = -1 idle, 0..3 computing, 4 write cycle.
  int          ph = -1;
  bit          armed = 1'b0;
  logic [1:0]  m_op, m_dst, m_reg;
  logic [31:0] m_a, m_b, m_out;

  always @(posedge clock) begin
    if (!reset) begin
      ph = -1; m_out = '0; m_reg = '0; armed = 1'b1;
    end else if (ph < 0) begin
      if (start) begin
        ph = 0; m_op = op; m_a = vdata1; m_b = vdata2; m_dst = vdst;
      end
    end else begin
      ph++;
      if (ph == 4) begin
        m_out = ref_alu(m_op, m_a, m_b);
        m_reg = m_dst;
      end else if (ph == 5) begin
        ph = -1;
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("cyc_busy", 32'(busy), 32'(ph >= 0));
      chk("cyc_vrfwrite", 32'(VRFWrite), 32'(ph == 4));
      if (ph < 0 || ph == 4) begin
        chk("cyc_vdataw", vdataw, m_out);
        chk("cyc_vregw", 32'(vregw), 32'(m_reg));
      end
    end
  end

  task automatic churn();
    vdata1 = $urandom; vdata2 = $urandom;
    vdst = 2'($urandom); op = 2'($urandom);
  endtask

  // Issue one op and wait (bounded) for its write pulse; lat counts
  // negedges from the one where start was driven.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] d, output logic [31:0] rd, output logic [1:0] rr,
                        output int lat);
    lat = -1; rd = 'x; rr = 'x;
    @(negedge clock);
    op = o; vdata1 = a; vdata2 = b; vdst = d; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (VRFWrite) begin
        lat = n; rd = vdataw; rr = vregw;
        break;
      end
      churn();
    end
    start = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;
  int          lat, pulses, last;

  initial begin
    reset = 1'b0; start = 1'b1; op = 2'd3; vdst = 2'd3;
    vdata1 = 32'hFFFF_FFFF; vdata2 = 32'h1234_5678;
    repeat (3) @(negedge clock);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_vrfwrite", 32'(VRFWrite), 0);
    chk("reset_vdataw", vdataw, 0);
    chk("reset_vregw", 32'(vregw), 0);
    start = 1'b0; reset = 1'b1;

    // Pin the reference against hand-computed vectors.
    chk("model_vand", ref_alu(2'd2, 32'h8001FF00, 32'h7F02FE01), 32'h0000FE00);
    chk("model_vmax", ref_alu(2'd3, 32'h8001FF00, 32'h7F02FE01), 32'h8002FF01);

    run_op(2'd0, 32'h01FF7F10, 32'h01018110, 2'd2, rd, rr, lat);
    chk("vadd_latency", 32'(lat), 5);
    chk("vadd_vregw", 32'(rr), 2);
`ifdef VLANE_SAT_EN
    chk("vadd_data", rd, 32'h02FFFF20);
`else
    chk("vadd_data", rd, 32'h02000020);
`endif

    run_op(2'd1, 32'h00100580, 32'h01200380, 2'd1, rd, rr, lat);
    chk("vsub_latency", 32'(lat), 5);
`ifdef VLANE_SAT_EN
    chk("vsub_data", rd, 32'h00000200);
`else
    chk("vsub_data", rd, 32'hFFF00200);
`endif

    run_op(2'd3, 32'h8001FF00, 32'h7F02FE01, 2'd3, rd, rr, lat);
    chk("vmax_data", rd, 32'h8002FF01);
    chk("vmax_vregw", 32'(rr), 3);
    run_op(2'd2, 32'h8001FF00, 32'h7F02FE01, 2'd0, rd, rr, lat);
    chk("vand_data", rd, 32'h0000FE00);
    chk("vand_vregw", 32'(rr), 0);

    // Random ops; operands churn every cycle after acceptance.
    for (int k = 0; k < 40; k++) begin
      logic [1:0]  o, d;
      logic [31:0] a, b;
      o = 2'($urandom); d = 2'($urandom); a = $urandom; b = $urandom;
      run_op(o, a, b, d, rd, rr, lat);
      chk("rand_latency", 32'(lat), 5);
      chk("rand_data", rd, ref_alu(o, a, b));
      chk("rand_vregw", 32'(rr), 32'(d));
    end

    // start held high: acceptance every 6 cycles, one pulse per op.
    @(negedge clock);
    churn(); start = 1'b1; pulses = 0; last = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (VRFWrite) begin
        pulses++;
        if (pulses == 1) chk("b2b_first", 32'(n), 5);
        else             chk("b2b_gap", 32'(n - last), 6);
        last = n;
      end
      churn();
    end
    start = 1'b0;
    chk("b2b_pulses", 32'(pulses), 5);

    // Reset during the third EXEC cycle aborts the op.
    @(negedge clock); @(negedge clock);
    churn(); start = 1'b1;
    @(negedge clock); start = 1'b0; churn();
    @(negedge clock); churn();
    @(negedge clock); reset = 1'b0; start = 1'b1;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_vdataw", vdataw, 0);
    chk("abort_vrfwrite", 32'(VRFWrite), 0);
    reset = 1'b1; start = 1'b0;
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      if (VRFWrite) pulses++;
    end
    chk("abort_no_write", 32'(pulses), 0);
    run_op(2'd0, 32'h11223344, 32'h01020304, 2'd1, rd, rr, lat);
    chk("post_abort_latency", 32'(lat), 5);
    chk("post_abort_data", rd, ref_alu(2'd0, 32'h11223344, 32'h01020304));

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
